// File: rtl/bcd_counter_4digit.sv
// bcd_counter_4digit: 4-digit BCD event counter with prescaler; define BCD_CNT_SATURATE_EN to hold at 9999 instead of wrapping
module bcd_counter_4digit #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  output logic [3:0]  digit0_o,
  output logic [3:0]  digit1_o,
  output logic [3:0]  digit2_o,
  output logic [3:0]  digit3_o,
  output logic        tick_o,
  output logic        carry_o
);
  logic [3:0][3:0] dig, nxt, ld;
  logic [4:0]      c;
  logic [30:0]     pre;
  logic            hit;
  assign hit = en_i && pre == 31'(TICK_DIV - 1);
  always_comb begin
    c[0] = 1'b1;
    nxt = dig;
    ld = '0;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = c[i] && dig[i] == 4'd9;
      nxt[i] = c[i] ? (dig[i] == 4'd9 ? 4'd0 : dig[i] + 4'd1) : dig[i];
      ld[i] = load_val_i[4*i +: 4] > 4'd9 ? 4'd0 : load_val_i[4*i +: 4];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig <= '0;
      pre <= '0;
      tick_o <= 1'b0;
      carry_o <= 1'b0;
    end else if (clr_i || load_i) begin
      dig <= clr_i ? '0 : ld;
      pre <= '0;
      tick_o <= 1'b0;
      carry_o <= 1'b0;
    end else begin
      tick_o <= hit;
      carry_o <= 1'b0;
      if (hit) begin
        pre <= '0;
`ifdef BCD_CNT_SATURATE_EN
        dig <= c[4] ? dig : nxt;
`else
        dig <= nxt;
        carry_o <= c[4];
`endif
      end else if (en_i) begin
        pre <= pre + 31'd1;
      end
    end
  end
  assign digit0_o = dig[0];
  assign digit1_o = dig[1];
  assign digit2_o = dig[2];
  assign digit3_o = dig[3];
endmodule

// File: tb/tb_bcd_counter_4digit.sv
// tb_bcd_counter_4digit: directed bench for bcd_counter_4digit with TICK_DIV=4
module tb_bcd_counter_4digit;
  logic        clk = 1'b0;
  logic        rst_n, en_i, clr_i, load_i;
  logic [15:0] load_val_i;
  logic [3:0]  digit0_o, digit1_o, digit2_o, digit3_o;
  logic        tick_o, carry_o;
  int checks = 0;
  int errors = 0;
  bcd_counter_4digit #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .clr_i(clr_i), .load_i(load_i),
    .load_val_i(load_val_i), .digit0_o(digit0_o), .digit1_o(digit1_o),
    .digit2_o(digit2_o), .digit3_o(digit3_o), .tick_o(tick_o), .carry_o(carry_o)
  );
  always #5 clk = ~clk;
  wire [15:0] digits = {digit3_o, digit2_o, digit1_o, digit0_o};
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [15:0] v);
    load_i = 1'b1;
    load_val_i = v;
    step(1);
    load_i = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; en_i = 1'b0; clr_i = 1'b0; load_i = 1'b0; load_val_i = '0;
    step(2);
    chk("reset_digits", digits, 16'h0000);
    chk("reset_tick", {15'd0, tick_o}, 16'd0);
    chk("reset_carry", {15'd0, carry_o}, 16'd0);
    rst_n = 1'b1;
    load(16'h0042);
    chk("load_0042", digits, 16'h0042);
    en_i = 1'b1;
    step(2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_digits", digits, 16'h0000);
    chk("async_rst_tick_carry", {14'd0, tick_o, carry_o}, 16'd0);
    en_i = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_hold", digits, 16'h0000);
    en_i = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      chk($sformatf("tick_cycle%0d", k), {15'd0, tick_o}, (k % 4 == 0) ? 16'd1 : 16'd0);
    end
    chk("count40", digits, 16'h0010);
    chk("count40_carry", {15'd0, carry_o}, 16'd0);
    en_i = 1'b0;
    step(1);
    chk("en_low_tick", {15'd0, tick_o}, 16'd0);
    load(16'h0199);
    chk("load_0199", digits, 16'h0199);
    en_i = 1'b1;
    step(3);
    chk("pre_tick_0199", {15'd0, tick_o}, 16'd0);
    step(1);
    chk("ripple_0200", digits, 16'h0200);
    chk("ripple_tick", {15'd0, tick_o}, 16'd1);
    chk("ripple_carry", {15'd0, carry_o}, 16'd0);
    en_i = 1'b0;
    load(16'h9999);
    chk("load_9999", digits, 16'h9999);
    en_i = 1'b1;
    step(4);
    chk("wrap_tick", {15'd0, tick_o}, 16'd1);
`ifdef BCD_CNT_SATURATE_EN
    chk("sat_digits", digits, 16'h9999);
    chk("sat_carry", {15'd0, carry_o}, 16'd0);
`else
    chk("wrap_digits", digits, 16'h0000);
    chk("wrap_carry", {15'd0, carry_o}, 16'd1);
`endif
    step(1);
    chk("carry_one_cycle", {15'd0, carry_o}, 16'd0);
    chk("tick_one_cycle", {15'd0, tick_o}, 16'd0);
    en_i = 1'b0;
    load(16'h1A2F);
    chk("load_invalid_nibbles", digits, 16'h1020);
    clr_i = 1'b1; load_i = 1'b1; load_val_i = 16'h5678;
    step(1);
    clr_i = 1'b0; load_i = 1'b0;
    chk("clr_over_load", digits, 16'h0000);
    en_i = 1'b1;
    step(2);
    en_i = 1'b0;
    step(10);
    chk("hold_tick", {15'd0, tick_o}, 16'd0);
    chk("hold_digits", digits, 16'h0000);
    en_i = 1'b1;
    step(1);
    chk("resume_1st", {15'd0, tick_o}, 16'd0);
    step(1);
    chk("resume_2nd_tick", {15'd0, tick_o}, 16'd1);
    chk("resume_digits", digits, 16'h0001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
